ps2_keyboard_display: RTL and testbench
=======================================

# ps2_keyboard_display

Receives PS/2 keyboard frames on the raw `keyb_clk`/`keyb_data` lines, decodes numeric-key make codes (0–9) and drives a single 7-segment digit. It sits between the board's PS/2 connector pins and one HEX display. It runs entirely in the system clock domain, oversampling the slow PS/2 clock. Internal registers `scan_code` and `number` are part of the verification-visible state; keep these names.

## Interface
- `TIMEOUT_CYCLES`, default 50000: system-clock cycles without a `keyb_clk` falling edge, mid-frame, after which the partial frame is discarded.
- `clk` input 1: system clock (100 MHz nominal). All logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `keyb_clk` input 1: raw PS/2 clock. Asynchronous; idles high.
- `keyb_data` input 1: raw PS/2 data. Asynchronous; idles high.
- `hex_display` output 7: segment drive, active-low; bit0=a … bit6=g.

## Operation
- Synchronization:
  - `keyb_clk` and `keyb_data` each pass through a 2-flop synchronizer.
  - A falling edge is a synchronized clock of 1 in the previous cycle and 0 in the current cycle.
- Frame format, sampled on each detected falling edge:
  - Start bit 0.
  - 8 data bits, LSB first.
  - Odd parity bit.
  - Stop bit 1.
- Receiver states:
  - IDLE: waits for a falling edge with data = 0 (start bit). Data = 1 at a falling edge is ignored and the state stays IDLE.
  - DATA: shifts in 8 bits, LSB first, into a shift register.
  - PARITY: captures the parity bit.
  - STOP: captures the stop bit, then returns to IDLE.
- Frame acceptance:
  - A frame is valid when the stop bit is 1 and the parity over data plus parity bit is odd.
  - Invalid frames are dropped silently. `scan_code` and `number` are not changed.
- On a valid frame, `scan_code` takes the received byte, including codes that are not digits.
- Break handling:
  - A valid byte 0xF0 sets a `break_pending` flag.
  - The next valid byte clears the flag and does not update `number`.
  - `scan_code` still records both bytes.
- Digit decode, applied only when `break_pending` = 0. `number` (4 bits) loads:
  - 0x45→0, 0x16→1, 0x1E→2, 0x26→3, 0x25→4
  - 0x2E→5, 0x36→6, 0x3D→7, 0x3E→8, 0x46→9
  - Any other code leaves `number` unchanged.
- `hex_display` is a combinational decode of `number`, active-low:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - Values 10–15 cannot occur; decode them to 1111111 (blank).
- Timeout:
  - A counter runs while the receiver is outside IDLE and clears on every falling edge.
  - When it reaches `TIMEOUT_CYCLES`, the receiver returns to IDLE and the partial frame is discarded.
- Reset, synchronous:
  - Receiver goes to IDLE; bit counter, timeout counter and `break_pending` clear.
  - `scan_code` = 0x00, `number` = 0, so `hex_display` = 1000000.
  - Synchronizer flops are set to 1 (idle).
  - Reset mid-frame discards the partial frame.

## Timing
- Input-to-edge latency: a `keyb_clk` fall is seen as a falling edge 3 rising edges of `clk` later (2 synchronizer stages + 1 edge-detect stage). `keyb_data` is delayed by the same amount, so it stays aligned with the edge.
- PS/2 clock limits:
  - Minimum high time 2 `clk` cycles; minimum low time 2 `clk` cycles.
  - Shorter pulses are outside the supported range.
- Update latency:
  - `scan_code`, `number` and `break_pending` update on the same `clk` edge that registers the stop bit.
  - `hex_display` changes combinationally in that same cycle.
- Back-to-back frames: a start bit may arrive on the very next falling edge after a stop bit and must be accepted.
- Outputs hold their value indefinitely between frames.

## Test plan
- Reset: assert `reset` for 2 cycles → `scan_code` = 0x00, `number` = 0, `hex_display` = 1000000.
- Five digits: send valid frames 0x16, 0x1E, 0x26, 0x25, 0x2E, with PS/2 half-periods of 10 `clk` cycles and 100-cycle gaps → after each frame, `scan_code` equals the byte sent and `number` = 1, 2, 3, 4, 5. `hex_display` = 1111001, 0100100, 0110000, 0011001, 0010010.
- Break sequence: digit 7 (0x3D), then 0xF0, 0x3D, then 0x45 →
  - `number` = 7 after 0x3D.
  - `number` stays 7 through the F0/3D pair, with `scan_code` reading 0xF0 then 0x3D.
  - `number` = 0 after 0x45.
- Parity error: send 0x46 with even parity → `scan_code` and `number` unchanged.
- Bad stop bit: send a frame with stop bit = 0 → frame dropped.
- Truncated frame: send start bit plus 4 data bits, idle for `TIMEOUT_CYCLES` + 10 cycles, then send a full valid 0x36 → `number` = 6.
- Non-digit and mid-frame reset:
  - Send 0x1C → `scan_code` = 0x1C, `number` unchanged.
  - Pulse `reset` mid-frame, then send a valid 0x3E → `number` = 8, `hex_display` = 0000000.

Source files
------------

// File: rtl/ps2_keyboard_display.sv
// ps2_keyboard_display
//   Receives PS/2 keyboard frames from the raw connector lines and oversamples
//   them in the system clock domain. Numeric-key make codes (0-9) are decoded
//   and shown on one active-low 7-segment digit. Break sequences (F0 xx) are
//   recognised, so key releases do not change the digit.
// Ports
//   clk         : system clock; all logic runs on its rising edge
//   reset       : synchronous, active-high
//   keyb_clk    : raw PS/2 clock (asynchronous, idles high)
//   keyb_data   : raw PS/2 data (asynchronous, idles high)
//   hex_display : segment drive, active-low, bit0=a .. bit6=g
module ps2_keyboard_display #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyb_clk,
  input  logic       keyb_data,
  output logic [6:0] hex_display
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      r_state, w_state_next;
  logic        r_kc_s1, r_kc_s2, r_kc_prev;
  logic        r_kd_s1, r_kd_s2;
  logic        w_fall;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_parity;
  logic [TW-1:0] r_to_cnt;
  logic        w_timeout;
  logic        w_frame_ok;
  logic [7:0]  scan_code;
  logic [3:0]  number;
  logic        r_break_pending;
  logic        w_digit_valid;
  logic [3:0]  w_digit;

  // Synchronizers park at 1 so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kc_s1   <= 1'b1;
      r_kc_s2   <= 1'b1;
      r_kc_prev <= 1'b1;
      r_kd_s1   <= 1'b1;
      r_kd_s2   <= 1'b1;
    end else begin
      r_kc_s1   <= keyb_clk;
      r_kc_s2   <= r_kc_s1;
      r_kc_prev <= r_kc_s2;
      r_kd_s1   <= keyb_data;
      r_kd_s2   <= r_kd_s1;
    end
  end

  // Data is taken from the same stage as the current clock sample, so the bit
  // acted on is aligned with the edge being detected.
  assign w_fall    = r_kc_prev & ~r_kc_s2;
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall && !r_kd_s2) w_state_next = S_DATA;
      S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_next = S_PARITY;
      S_PARITY: if (w_fall) w_state_next = S_STOP;
      S_STOP:   if (w_fall) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    // An edge arriving in the same cycle keeps the frame alive.
    if (r_state != S_IDLE && !w_fall && w_timeout) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                          r_to_cnt <= r_to_cnt + TW'(1);
      if (w_fall) begin
        case (r_state)
          S_IDLE: r_bit_cnt <= 3'd0;
          S_DATA: begin
            r_shift   <= {r_kd_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= r_kd_s2;
          default: ;
        endcase
      end
    end
  end

  assign w_frame_ok = (r_state == S_STOP) && w_fall && r_kd_s2 && (^{r_shift, r_parity});

  always_comb begin
    w_digit_valid = 1'b1;
    w_digit       = 4'd0;
    case (r_shift)
      8'h45: w_digit = 4'd0;
      8'h16: w_digit = 4'd1;
      8'h1E: w_digit = 4'd2;
      8'h26: w_digit = 4'd3;
      8'h25: w_digit = 4'd4;
      8'h2E: w_digit = 4'd5;
      8'h36: w_digit = 4'd6;
      8'h3D: w_digit = 4'd7;
      8'h3E: w_digit = 4'd8;
      8'h46: w_digit = 4'd9;
      default: w_digit_valid = 1'b0;
    endcase
  end

  // The byte after F0 is the released key: record it, but leave the digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_code       <= 8'h00;
      number          <= 4'd0;
      r_break_pending <= 1'b0;
    end else if (w_frame_ok) begin
      scan_code <= r_shift;
      if (r_break_pending)      r_break_pending <= 1'b0;
      else if (r_shift == 8'hF0) r_break_pending <= 1'b1;
      else if (w_digit_valid)    number <= w_digit;
    end
  end

  always_comb begin
    hex_display = 7'b1111111;
    case (number)
      4'd0: hex_display = 7'b1000000;
      4'd1: hex_display = 7'b1111001;
      4'd2: hex_display = 7'b0100100;
      4'd3: hex_display = 7'b0110000;
      4'd4: hex_display = 7'b0011001;
      4'd5: hex_display = 7'b0010010;
      4'd6: hex_display = 7'b0000010;
      4'd7: hex_display = 7'b1111000;
      4'd8: hex_display = 7'b0000000;
      4'd9: hex_display = 7'b0010000;
      default: hex_display = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard_display.sv
// Testbench for ps2_keyboard_display: directed vector table, hand-written
// timeout / reset / back-to-back sequences, then randomized frames checked
// against a key-level reference model.
module tb_ps2_keyboard_display;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kc = 1'b1;
  logic       kd = 1'b1;
  logic [6:0] hex;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps2_keyboard_display #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .keyb_clk(kc), .keyb_data(kd), .hex_display(hex)
  );

  // Reference model: what the keyboard has told us so far.
  logic [7:0] keys [0:9] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [6:0] segs [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};
  logic [7:0] m_scan;
  logic [3:0] m_num;
  bit         m_brk;

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (keys[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_scan = 8'h00; m_num = 4'd0; m_brk = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] code, input bit pok, input bit sok);
    int d;
    if (!(pok && sok)) return;
    m_scan = code;
    d = digit_of(code);
    if (m_brk)              m_brk = 1'b0;
    else if (code == 8'hF0) m_brk = 1'b1;
    else if (d >= 0)        m_num = 4'(d);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] s, input logic [3:0] n, input logic [6:0] h);
    check({tag, " scan_code"}, 32'(dut.scan_code), 32'(s));
    check({tag, " number"}, 32'(dut.number), 32'(n));
    check({tag, " hex_display"}, 32'(hex), 32'(h));
  endtask

  task automatic check_model(input string tag);
    check_out(tag, m_scan, m_num, segs[m_num]);
  endtask

  // Bits go out LSB first; data changes while the PS/2 clock is high.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      kd = bits[i];
      repeat (half) @(negedge clk);
      kc = 1'b0;
      repeat (half) @(negedge clk);
      kc = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] code, input bit pok, input bit sok);
    logic p;
    p = pok ? ~^code : ^code;
    return {sok, p, code, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] code, input bit pok, input bit sok, input int half);
    send_bits(frame_bits(code, pok, sok), 11, half);
    kd = 1'b1;
    $display("frame code=%02h par_ok=%0d stop_ok=%0d half=%0d", code, pok, sok, half);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         pok;
    bit         sok;
    logic [7:0] e_scan;
    logic [3:0] e_num;
    logic [6:0] e_hex;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [10:0] b;
    logic [7:0]  code;
    bit          pok, sok;

    tbl[0]  = '{8'h16, 1, 1, 8'h16, 4'd1, 7'b1111001};
    tbl[1]  = '{8'h1E, 1, 1, 8'h1E, 4'd2, 7'b0100100};
    tbl[2]  = '{8'h26, 1, 1, 8'h26, 4'd3, 7'b0110000};
    tbl[3]  = '{8'h25, 1, 1, 8'h25, 4'd4, 7'b0011001};
    tbl[4]  = '{8'h2E, 1, 1, 8'h2E, 4'd5, 7'b0010010};
    tbl[5]  = '{8'h3D, 1, 1, 8'h3D, 4'd7, 7'b1111000};
    tbl[6]  = '{8'hF0, 1, 1, 8'hF0, 4'd7, 7'b1111000};
    tbl[7]  = '{8'h3D, 1, 1, 8'h3D, 4'd7, 7'b1111000};
    tbl[8]  = '{8'h45, 1, 1, 8'h45, 4'd0, 7'b1000000};
    tbl[9]  = '{8'h46, 0, 1, 8'h45, 4'd0, 7'b1000000};
    tbl[10] = '{8'h36, 1, 0, 8'h45, 4'd0, 7'b1000000};
    tbl[11] = '{8'h1C, 1, 1, 8'h1C, 4'd0, 7'b1000000};
    tbl[12] = '{8'h46, 1, 1, 8'h46, 4'd9, 7'b0010000};
    tbl[13] = '{8'h3E, 1, 1, 8'h3E, 4'd8, 7'b0000000};
    tbl[14] = '{8'h36, 1, 1, 8'h36, 4'd6, 7'b0000010};
    tbl[15] = '{8'hF0, 1, 1, 8'hF0, 4'd6, 7'b0000010};
    tbl[16] = '{8'h1E, 0, 1, 8'hF0, 4'd6, 7'b0000010};
    tbl[17] = '{8'h1E, 1, 1, 8'h1E, 4'd6, 7'b0000010};
    tbl[18] = '{8'h1E, 1, 1, 8'h1E, 4'd2, 7'b0100100};

    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_out("reset", 8'h00, 4'd0, 7'b1000000);

    // Directed table
    for (int i = 0; i < 19; i++) begin
      send_frame(tbl[i].code, tbl[i].pok, tbl[i].sok, 10);
      model_frame(tbl[i].code, tbl[i].pok, tbl[i].sok);
      repeat (100) @(negedge clk);
      check_out($sformatf("tbl%0d", i), tbl[i].e_scan, tbl[i].e_num, tbl[i].e_hex);
    end

    // Truncated frame: start + 4 data bits, then silence beyond the timeout.
    send_bits(frame_bits(8'h16, 1, 1), 5, 10);
    kd = 1'b1;
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h36, 1, 1, 10);
    model_frame(8'h36, 1, 1);
    repeat (20) @(negedge clk);
    check_out("truncated", 8'h36, 4'd6, 7'b0000010);

    // Slow but legal frame: long pause mid-frame, shorter than the timeout.
    b = frame_bits(8'h25, 1, 1);
    send_bits(b, 5, 10);
    repeat (TO - 100) @(negedge clk);
    send_bits(b >> 5, 6, 10);
    kd = 1'b1;
    model_frame(8'h25, 1, 1);
    repeat (20) @(negedge clk);
    check_out("slow_frame", 8'h25, 4'd4, 7'b0011001);

    // Mid-frame reset
    send_bits(frame_bits(8'h26, 1, 1), 4, 10);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    kd = 1'b1;
    model_reset();
    @(negedge clk);
    check_out("midreset", 8'h00, 4'd0, 7'b1000000);
    send_frame(8'h3E, 1, 1, 10);
    model_frame(8'h3E, 1, 1);
    repeat (20) @(negedge clk);
    check_out("after_reset", 8'h3E, 4'd8, 7'b0000000);

    // Back-to-back: break prefix immediately followed by a key byte.
    send_frame(8'hF0, 1, 1, 3);
    send_frame(8'h1E, 1, 1, 3);
    model_frame(8'hF0, 1, 1);
    model_frame(8'h1E, 1, 1);
    repeat (20) @(negedge clk);
    check_out("back2back", 8'h1E, 4'd8, 7'b0000000);

    // Randomized frames against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: code = keys[$urandom_range(0, 9)];
        3:       code = 8'hF0;
        default: code = 8'($urandom);
      endcase
      pok = ($urandom_range(0, 9) != 0);
      sok = ($urandom_range(0, 19) != 0);
      send_frame(code, pok, sok, $urandom_range(2, 12));
      model_frame(code, pok, sok);
      repeat (6) @(negedge clk);
      check_model($sformatf("rand%0d", i));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
